// File: rtl/kianv_bus_fabric_pkg.sv
// Shared types and constants for the KianV valid/ready bus fabric.
// State encodings, bus widths, fault read-data value and a select-width helper.
package kianv_bus_fabric_pkg;

   localparam int          BUS_DATA_W  = 32;
   localparam int          BUS_ADDR_W  = 32;
   localparam logic [31:0] FAULT_RDATA = 32'h0;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } bus_state_t;

   function automatic int sel_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/kianv_bus_fabric_bus_addr_decode.sv
// bus_addr_decode: combinational priority address decoder for the bus fabric.
// Lowest-index matching window wins; flags writes that land on a read-only slave.
module bus_addr_decode
   import kianv_bus_fabric_pkg::*;
#(
   parameter int                        NUM_SLAVES = 4,
   parameter logic [NUM_SLAVES*32-1:0]  SLAVE_BASE = '0,
   parameter logic [NUM_SLAVES*32-1:0]  SLAVE_MASK = '0,
   parameter logic [NUM_SLAVES-1:0]     SLAVE_RO   = '0,
   parameter int                        SEL_W      = sel_width(NUM_SLAVES)
) (
   input  logic [BUS_ADDR_W-1:0] addr_i,
   input  logic                  wr_i,
   output logic                  hit_o,
   output logic [SEL_W-1:0]      sel_o,
   output logic                  ro_violation_o
);

   // Scan high to low so the lowest matching index is the last one written.
   always_comb begin
      hit_o          = 1'b0;
      sel_o          = '0;
      ro_violation_o = 1'b0;
      for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
         if ((addr_i & SLAVE_MASK[i*32 +: 32]) == SLAVE_BASE[i*32 +: 32]) begin
            hit_o          = 1'b1;
            sel_o          = SEL_W'(i);
            ro_violation_o = SLAVE_RO[i] & wr_i;
         end
      end
   end

endmodule

// File: rtl/kianv_bus_fabric.sv
// kianv_bus_fabric: valid/ready fabric from the KianV core to NUM_SLAVES peripherals.
// Optional ACCESS-state watchdog enabled by defining BUS_TIMEOUT_EN.
module kianv_bus_fabric
   import kianv_bus_fabric_pkg::*;
#(
   parameter int                        NUM_SLAVES = 4,
   parameter logic [NUM_SLAVES*32-1:0]  SLAVE_BASE = '0,
   parameter logic [NUM_SLAVES*32-1:0]  SLAVE_MASK = '0,
   parameter logic [NUM_SLAVES-1:0]     SLAVE_RO   = '0,
   parameter int                        TIMEOUT    = 1024
) (
   input  logic                             clk_i,
   input  logic                             rst_i,
   input  logic                             m_valid_i,
   input  logic [BUS_ADDR_W-1:0]            m_addr_i,
   input  logic [3:0]                       m_wstrb_i,
   input  logic [BUS_DATA_W-1:0]            m_wdata_i,
   output logic [BUS_DATA_W-1:0]            m_rdata_o,
   output logic                             m_ready_o,
   output logic                             m_fault_o,
   output logic [NUM_SLAVES-1:0]            s_valid_o,
   output logic [BUS_ADDR_W-1:0]            s_addr_o,
   output logic [3:0]                       s_wstrb_o,
   output logic [BUS_DATA_W-1:0]            s_wdata_o,
   input  logic [NUM_SLAVES*BUS_DATA_W-1:0] s_rdata_i,
   input  logic [NUM_SLAVES-1:0]            s_ready_i
);

   localparam int SEL_W = sel_width(NUM_SLAVES);

   if (NUM_SLAVES < 1 || NUM_SLAVES > 16 || TIMEOUT < 1) begin : g_param_check
      $error("kianv_bus_fabric: NUM_SLAVES must be 1..16 and TIMEOUT >= 1");
   end

   bus_state_t              state_q, state_d;
   logic [SEL_W-1:0]        sel_q, sel_d;
   logic [NUM_SLAVES-1:0]   sel_oh_q, sel_oh_d;
   logic [BUS_ADDR_W-1:0]   addr_q, addr_d;
   logic [3:0]              wstrb_q, wstrb_d;
   logic [BUS_DATA_W-1:0]   wdata_q, wdata_d;
   logic [BUS_DATA_W-1:0]   rdata_q, rdata_d;
   logic                    fault_q, fault_d;

   logic                    dec_hit, dec_ro;
   logic [SEL_W-1:0]        dec_sel;
   logic                    sel_rdy;
   logic [BUS_DATA_W-1:0]   sel_rdata;
   logic                    tmo;

   bus_addr_decode #(
      .NUM_SLAVES (NUM_SLAVES),
      .SLAVE_BASE (SLAVE_BASE),
      .SLAVE_MASK (SLAVE_MASK),
      .SLAVE_RO   (SLAVE_RO),
      .SEL_W      (SEL_W)
   ) u_decode (
      .addr_i         (m_addr_i),
      .wr_i           (|m_wstrb_i),
      .hit_o          (dec_hit),
      .sel_o          (dec_sel),
      .ro_violation_o (dec_ro)
   );

   // Only the latched slave's ready counts; others are ignored.
   assign sel_rdy   = |(s_ready_i & sel_oh_q);
   assign sel_rdata = s_rdata_i[sel_q*BUS_DATA_W +: BUS_DATA_W];

`ifdef BUS_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Zero outside ACCESS, so it is already clear on entry.
   always_comb begin
      cnt_d = '0;
      if (state_q == ST_ACCESS) cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign tmo = (cnt_q == CNT_W'(TIMEOUT - 1));
`else
   assign tmo = 1'b0;
`endif

   always_comb begin
      state_d  = state_q;
      sel_d    = sel_q;
      sel_oh_d = sel_oh_q;
      addr_d   = addr_q;
      wstrb_d  = wstrb_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      fault_d  = fault_q;
      case (state_q)
         ST_IDLE: begin
            if (m_valid_i) begin
               addr_d  = m_addr_i;
               wdata_d = m_wdata_i;
               if (!dec_hit || dec_ro) begin
                  wstrb_d = '0;
                  rdata_d = FAULT_RDATA;
                  fault_d = 1'b1;
                  state_d = ST_RESP;
               end else begin
                  wstrb_d  = m_wstrb_i;
                  sel_d    = dec_sel;
                  sel_oh_d = NUM_SLAVES'(1) << dec_sel;
                  state_d  = ST_ACCESS;
               end
            end
         end
         ST_ACCESS: begin
            // A ready arriving on the timeout cycle still wins.
            if (sel_rdy) begin
               rdata_d = sel_rdata;
               fault_d = 1'b0;
               state_d = ST_RESP;
            end else if (tmo) begin
               rdata_d = FAULT_RDATA;
               fault_d = 1'b1;
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            fault_d = 1'b0;
            state_d = ST_IDLE;
         end
         default: begin
            fault_d = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= ST_IDLE;
         sel_q    <= '0;
         sel_oh_q <= '0;
         addr_q   <= '0;
         wstrb_q  <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         fault_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         sel_q    <= sel_d;
         sel_oh_q <= sel_oh_d;
         addr_q   <= addr_d;
         wstrb_q  <= wstrb_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
         fault_q  <= fault_d;
      end
   end

   assign m_ready_o = (state_q == ST_RESP);
   assign m_fault_o = fault_q;
   assign m_rdata_o = rdata_q;
   assign s_valid_o = (state_q == ST_ACCESS) ? sel_oh_q : '0;
   assign s_addr_o  = addr_q;
   assign s_wstrb_o = wstrb_q;
   assign s_wdata_o = wdata_q;

endmodule
